// File: rtl/forwarding_scoreboard_unit_pkg.sv
// Shared constants for the forwarding/scoreboard unit: forward-select encodings and default widths.
package forwarding_scoreboard_unit_pkg;

  localparam int unsigned DEFAULT_REG_AW = 5;
  localparam int unsigned DEFAULT_LAT_W  = 3;
  localparam int unsigned FWD_W          = 2;

  typedef logic [FWD_W-1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_NONE   = 2'b00;
  localparam fwd_sel_t FWD_EX_MEM = 2'b01;
  localparam fwd_sel_t FWD_MEM_WB = 2'b10;

endpackage

// File: rtl/forwarding_scoreboard_unit_lane.sv
// Single-lane forward select: EX/MEM beats MEM/WB, register x0 is never forwarded.
module forward_select_lane
  import forwarding_scoreboard_unit_pkg::*;
#(
  parameter int unsigned REG_AW = DEFAULT_REG_AW
) (
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [REG_AW-1:0] ex_mem_rd_addr,
  input  logic              ex_mem_reg_write,
  input  logic [REG_AW-1:0] mem_wb_rd_addr,
  input  logic              mem_wb_reg_write,
  output fwd_sel_t          fwd_sel_c
);

  always_comb begin
    fwd_sel_c = FWD_NONE;
    if (ex_mem_reg_write && (ex_mem_rd_addr != '0) && (ex_mem_rd_addr == rs_addr)) begin
      fwd_sel_c = FWD_EX_MEM;
    end else if (mem_wb_reg_write && (mem_wb_rd_addr != '0) && (mem_wb_rd_addr == rs_addr)) begin
      fwd_sel_c = FWD_MEM_WB;
    end
  end

endmodule

// File: rtl/forwarding_scoreboard_unit.sv
// N-lane operand forwarding, load-use stall and long-latency register scoreboard.
// Optional stall performance counter enabled by defining FWD_STALL_COUNTER_EN.
module forwarding_scoreboard_unit
  import forwarding_scoreboard_unit_pkg::*;
#(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned REG_AW  = DEFAULT_REG_AW,
  parameter int unsigned LAT_W   = DEFAULT_LAT_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*REG_AW-1:0] ex_rs_addr,
  input  logic [REG_AW-1:0]         ex_mem_rd_addr,
  input  logic                      ex_mem_reg_write,
  input  logic [REG_AW-1:0]         mem_wb_rd_addr,
  input  logic                      mem_wb_reg_write,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs_addr,
  input  logic [NUM_SRC-1:0]        id_rs_used,
  input  logic [REG_AW-1:0]         id_ex_rd_addr,
  input  logic                      id_ex_mem_read,
  input  logic                      issue_valid,
  input  logic [REG_AW-1:0]         issue_rd_addr,
  input  logic                      issue_reg_write,
  input  logic [LAT_W-1:0]          issue_latency,
  input  logic                      flush,
  output logic [NUM_SRC*2-1:0]      forward_sel,
  output logic                      stall,
  output logic                      issue_fire,
  output logic [31:0]               stall_cycles
);

  localparam int unsigned NUM_REG = 2**REG_AW;

  logic [NUM_SRC*2-1:0] lane_sel;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_lane
    forward_select_lane #(.REG_AW(REG_AW)) u_lane (
      .rs_addr          (ex_rs_addr[i*REG_AW +: REG_AW]),
      .ex_mem_rd_addr   (ex_mem_rd_addr),
      .ex_mem_reg_write (ex_mem_reg_write),
      .mem_wb_rd_addr   (mem_wb_rd_addr),
      .mem_wb_reg_write (mem_wb_reg_write),
      .fwd_sel_c        (lane_sel[i*2 +: 2])
    );
  end

  assign forward_sel = rst ? '0 : lane_sel;

  logic [NUM_REG-1:0] pend_q, pend_d;
  logic [LAT_W-1:0]   cnt_q [NUM_REG];
  logic [LAT_W-1:0]   cnt_d [NUM_REG];
  logic [NUM_REG-1:0] busy;
  logic               load_use, raw, waw, alloc;

  // An entry in its final (count==1) cycle is forwardable, so it no longer blocks.
  always_comb begin
    busy = '0;
    for (int r = 1; r < NUM_REG; r++) begin
      busy[r] = pend_q[r] && (cnt_q[r] != LAT_W'(1));
    end
  end

  always_comb begin
    load_use = 1'b0;
    raw      = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id_rs_used[i] && (id_rs_addr[i*REG_AW +: REG_AW] != '0) && id_ex_mem_read &&
          (id_ex_rd_addr == id_rs_addr[i*REG_AW +: REG_AW])) begin
        load_use = 1'b1;
      end
      if (id_rs_used[i] && busy[id_rs_addr[i*REG_AW +: REG_AW]]) begin
        raw = 1'b1;
      end
    end
    waw        = issue_reg_write && busy[issue_rd_addr];
    stall      = !rst && issue_valid && !flush && (load_use || raw || waw);
    issue_fire = !rst && issue_valid && !flush && !stall;
    alloc      = issue_fire && issue_reg_write && (issue_rd_addr != '0) && (issue_latency != '0);
  end

  // Countdown every entry; a same-cycle allocation wins over expiry.
  always_comb begin
    pend_d = pend_q;
    for (int r = 0; r < NUM_REG; r++) begin
      cnt_d[r] = cnt_q[r];
      if (cnt_q[r] != '0) begin
        cnt_d[r] = cnt_q[r] - LAT_W'(1);
        if (cnt_q[r] == LAT_W'(1)) begin
          pend_d[r] = 1'b0;
        end
      end
      if (alloc && (issue_rd_addr == REG_AW'(r))) begin
        pend_d[r] = 1'b1;
        cnt_d[r]  = issue_latency;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      for (int r = 0; r < NUM_REG; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      pend_q <= pend_d;
      for (int r = 0; r < NUM_REG; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

`ifdef FWD_STALL_COUNTER_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_forwarding_scoreboard_unit.sv
// Directed-vector scoreboard bench: stimulus queues expected outputs, a negedge monitor compares.
module tb_forwarding_scoreboard_unit;

  localparam int unsigned NUM_SRC = 2;
  localparam int unsigned REG_AW  = 5;
  localparam int unsigned LAT_W   = 3;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_SRC*REG_AW-1:0] ex_rs_addr;
  logic [REG_AW-1:0]         ex_mem_rd_addr;
  logic                      ex_mem_reg_write;
  logic [REG_AW-1:0]         mem_wb_rd_addr;
  logic                      mem_wb_reg_write;
  logic [NUM_SRC*REG_AW-1:0] id_rs_addr;
  logic [NUM_SRC-1:0]        id_rs_used;
  logic [REG_AW-1:0]         id_ex_rd_addr;
  logic                      id_ex_mem_read;
  logic                      issue_valid;
  logic [REG_AW-1:0]         issue_rd_addr;
  logic                      issue_reg_write;
  logic [LAT_W-1:0]          issue_latency;
  logic                      flush;
  logic [NUM_SRC*2-1:0]      forward_sel;
  logic                      stall;
  logic                      issue_fire;
  logic [31:0]               stall_cycles;

  forwarding_scoreboard_unit #(.NUM_SRC(NUM_SRC), .REG_AW(REG_AW), .LAT_W(LAT_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .ex_rs_addr       (ex_rs_addr),
    .ex_mem_rd_addr   (ex_mem_rd_addr),
    .ex_mem_reg_write (ex_mem_reg_write),
    .mem_wb_rd_addr   (mem_wb_rd_addr),
    .mem_wb_reg_write (mem_wb_reg_write),
    .id_rs_addr       (id_rs_addr),
    .id_rs_used       (id_rs_used),
    .id_ex_rd_addr    (id_ex_rd_addr),
    .id_ex_mem_read   (id_ex_mem_read),
    .issue_valid      (issue_valid),
    .issue_rd_addr    (issue_rd_addr),
    .issue_reg_write  (issue_reg_write),
    .issue_latency    (issue_latency),
    .flush            (flush),
    .forward_sel      (forward_sel),
    .stall            (stall),
    .issue_fire       (issue_fire),
    .stall_cycles     (stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [3:0]  fwd;
    logic        st;
    logic        fire;
    logic [31:0] sc;
  } exp_t;

  exp_t        q[$];
  int          n_vec  = 0;
  int          n_bad  = 0;
  logic [31:0] exp_sc = 32'd0;

  task automatic clr();
    ex_rs_addr = '0; ex_mem_rd_addr = '0; ex_mem_reg_write = 1'b0;
    mem_wb_rd_addr = '0; mem_wb_reg_write = 1'b0;
    id_rs_addr = '0; id_rs_used = '0; id_ex_rd_addr = '0; id_ex_mem_read = 1'b0;
    issue_valid = 1'b0; issue_rd_addr = '0; issue_reg_write = 1'b0;
    issue_latency = '0; flush = 1'b0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic expect_out(input string tag, input logic [3:0] efwd, input logic est,
                            input logic efire);
    exp_t e;
    e.tag = tag; e.fwd = efwd; e.st = est; e.fire = efire;
`ifdef FWD_STALL_COUNTER_EN
    e.sc = exp_sc;
`else
    e.sc = 32'd0;
`endif
    q.push_back(e);
    if (rst) exp_sc = 32'd0;
    else if (est && exp_sc != 32'hFFFF_FFFF) exp_sc = exp_sc + 32'd1;
  endtask

  task automatic issue(input logic [4:0] rd, input logic wr, input logic [2:0] lat);
    issue_valid = 1'b1; issue_rd_addr = rd; issue_reg_write = wr; issue_latency = lat;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_vec++;
      if (forward_sel !== e.fwd || stall !== e.st || issue_fire !== e.fire ||
          stall_cycles !== e.sc) begin
        n_bad++;
        $display("FAIL %s: got fwd=%b stall=%b fire=%b sc=%0d, want fwd=%b stall=%b fire=%b sc=%0d",
                 e.tag, forward_sel, stall, issue_fire, stall_cycles,
                 e.fwd, e.st, e.fire, e.sc);
      end
    end
  end

  initial begin
    rst = 1'b1;
    clr();
    repeat (2) @(posedge clk);
    #1;
    // reset holds outputs low despite active inputs
    ex_rs_addr = {5'd0, 5'd5}; ex_mem_rd_addr = 5'd5; ex_mem_reg_write = 1'b1;
    id_ex_mem_read = 1'b1; id_ex_rd_addr = 5'd7; id_rs_addr = {5'd0, 5'd7}; id_rs_used = 2'b01;
    issue(5'd3, 1'b1, 3'd0);
    expect_out("rst_hold", 4'b0000, 1'b0, 1'b0);
    nxt(); rst = 1'b0;
    expect_out("idle", 4'b0000, 1'b0, 1'b0);

    nxt(); ex_rs_addr = {5'd3, 5'd5}; ex_mem_rd_addr = 5'd5; ex_mem_reg_write = 1'b1;
    mem_wb_rd_addr = 5'd5; mem_wb_reg_write = 1'b1;
    expect_out("fwd_prio", 4'b0001, 1'b0, 1'b0);
    nxt(); ex_rs_addr = {5'd5, 5'd5}; ex_mem_rd_addr = 5'd5;
    mem_wb_rd_addr = 5'd5; mem_wb_reg_write = 1'b1;
    expect_out("fwd_memwb", 4'b1010, 1'b0, 1'b0);
    nxt(); ex_mem_reg_write = 1'b1; mem_wb_reg_write = 1'b1;
    expect_out("fwd_x0", 4'b0000, 1'b0, 1'b0);
    nxt(); ex_rs_addr = {5'd6, 5'd12}; ex_mem_rd_addr = 5'd6; ex_mem_reg_write = 1'b1;
    mem_wb_rd_addr = 5'd12; mem_wb_reg_write = 1'b1;
    expect_out("fwd_mixed", 4'b0110, 1'b0, 1'b0);

    nxt(); id_ex_mem_read = 1'b1; id_ex_rd_addr = 5'd7; id_rs_addr = {5'd7, 5'd0};
    id_rs_used = 2'b10; issue(5'd8, 1'b1, 3'd0);
    expect_out("load_use", 4'b0000, 1'b1, 1'b0);
    nxt(); id_ex_rd_addr = 5'd7; id_rs_addr = {5'd7, 5'd0}; id_rs_used = 2'b10;
    issue(5'd8, 1'b1, 3'd0);
    expect_out("load_use_done", 4'b0000, 1'b0, 1'b1);
    nxt(); id_ex_mem_read = 1'b1; id_ex_rd_addr = 5'd7; id_rs_addr = {5'd7, 5'd3};
    id_rs_used = 2'b01; issue(5'd8, 1'b1, 3'd0);
    expect_out("load_unused", 4'b0000, 1'b0, 1'b1);
    nxt(); id_ex_mem_read = 1'b1; id_rs_used = 2'b01; issue(5'd8, 1'b1, 3'd0);
    expect_out("load_x0", 4'b0000, 1'b0, 1'b1);

    nxt(); issue(5'd9, 1'b1, 3'd3);
    expect_out("raw_alloc", 4'b0000, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      nxt(); id_rs_addr = {5'd0, 5'd9}; id_rs_used = 2'b01; issue(5'd10, 1'b1, 3'd0);
      expect_out($sformatf("raw_t%0d", k + 1), 4'b0000, k < 2, k >= 2);
    end

    nxt(); issue(5'd4, 1'b1, 3'd2);
    expect_out("waw_alloc", 4'b0000, 1'b0, 1'b1);
    nxt(); issue(5'd4, 1'b1, 3'd0);
    expect_out("waw_stall", 4'b0000, 1'b1, 1'b0);
    nxt(); issue(5'd4, 1'b1, 3'd3);
    expect_out("waw_realloc", 4'b0000, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      nxt(); id_rs_addr = {5'd0, 5'd4}; id_rs_used = 2'b01; issue(5'd0, 1'b0, 3'd0);
      expect_out($sformatf("realloc_t%0d", k + 1), 4'b0000, k < 2, k == 2);
    end

    nxt(); issue(5'd11, 1'b1, 3'd3);
    expect_out("fl_alloc", 4'b0000, 1'b0, 1'b1);
    nxt(); id_rs_addr = {5'd0, 5'd11}; id_rs_used = 2'b01; issue(5'd0, 1'b0, 3'd0);
    expect_out("fl_stall", 4'b0000, 1'b1, 1'b0);
    nxt(); id_rs_addr = {5'd0, 5'd11}; id_rs_used = 2'b01; issue(5'd12, 1'b1, 3'd5);
    flush = 1'b1;
    expect_out("fl_flush", 4'b0000, 1'b0, 1'b0);
    nxt(); id_rs_addr = {5'd11, 5'd12}; id_rs_used = 2'b11; issue(5'd0, 1'b0, 3'd0);
    expect_out("fl_expire", 4'b0000, 1'b0, 1'b1);

    nxt(); issue(5'd13, 1'b1, 3'd7);
    expect_out("rs_alloc", 4'b0000, 1'b0, 1'b1);
    nxt(); id_rs_addr = {5'd0, 5'd13}; id_rs_used = 2'b01; issue(5'd0, 1'b0, 3'd0);
    expect_out("rs_stall", 4'b0000, 1'b1, 1'b0);
    nxt(); rst = 1'b1; id_rs_addr = {5'd0, 5'd13}; id_rs_used = 2'b01; issue(5'd0, 1'b0, 3'd0);
    ex_rs_addr = {5'd0, 5'd2}; ex_mem_rd_addr = 5'd2; ex_mem_reg_write = 1'b1;
    expect_out("rs_pulse", 4'b0000, 1'b0, 1'b0);
    nxt(); rst = 1'b0; id_rs_addr = {5'd0, 5'd13}; id_rs_used = 2'b01; issue(5'd0, 1'b0, 3'd0);
    expect_out("rs_cleared", 4'b0000, 1'b0, 1'b1);

    nxt(); issue(5'd14, 1'b1, 3'd7);
    expect_out("cnt_alloc", 4'b0000, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      nxt(); id_rs_addr = {5'd0, 5'd14}; id_rs_used = 2'b01; issue(5'd0, 1'b0, 3'd0);
      expect_out($sformatf("cnt_stall%0d", k + 1), 4'b0000, 1'b1, 1'b0);
    end
    nxt();
    expect_out("cnt_final", 4'b0000, 1'b0, 1'b0);
    nxt();
    expect_out("cnt_hold", 4'b0000, 1'b0, 1'b0);

    for (int w = 0; w < 20 && q.size() > 0; w++) @(posedge clk);
    @(posedge clk);
    if (q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected entries never checked, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/forwarding_scoreboard_unit.md
Name: forwarding_scoreboard_unit

Overview:
- Parametrised successor to the pipeline forwarding logic: N source-operand lanes instead of two.
- Forward selection for EX-stage operands from EX/MEM and MEM/WB.
- Load-use stall for decode-stage operands.
- Register scoreboard with per-register countdown for long-latency ops (mul/div, multi-cycle loads), giving RAW and WAW stalls.
- Sits beside the ID/EX boundary; drives EX operand muxes and the IF/ID / PC stall.

Parameters:
- NUM_SRC, 2, number of source-operand lanes (1..4).
- REG_AW, 5, register address width; register count = 2**REG_AW.
- LAT_W, 3, width of the issue latency field; max latency = 2**LAT_W-1 cycles.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ex_rs_addr  in  NUM_SRC*REG_AW  EX-stage source addresses; lane i = bits [i*REG_AW +: REG_AW]
- ex_mem_rd_addr  in  REG_AW  EX/MEM destination
- ex_mem_reg_write  in  1  EX/MEM write enable
- mem_wb_rd_addr  in  REG_AW  MEM/WB destination
- mem_wb_reg_write  in  1  MEM/WB write enable
- id_rs_addr  in  NUM_SRC*REG_AW  decode-stage source addresses
- id_rs_used  in  NUM_SRC  per-lane "operand actually read" qualifier
- id_ex_rd_addr  in  REG_AW  destination of the instruction currently in ID/EX
- id_ex_mem_read  in  1  instruction in ID/EX is a load
- issue_valid  in  1  decode instruction requests issue this cycle
- issue_rd_addr  in  REG_AW  destination of the issuing instruction
- issue_reg_write  in  1  issuing instruction writes rd
- issue_latency  in  LAT_W  extra cycles before the result is forwardable; 0 = normal ALU op
- flush  in  1  squash decode instruction this cycle
- forward_sel  out  NUM_SRC*2  per-lane select: 00 none, 01 EX/MEM, 10 MEM/WB
- stall  out  1  hold PC and IF/ID; insert bubble into ID/EX
- issue_fire  out  1  issue accepted (issue_valid & ~stall & ~flush)
- stall_cycles  out  32  performance counter (see Optional Feature)

Behaviour:
- Reset (rst=1 at clk edge):
  - All scoreboard pending bits and counters cleared.
  - stall_cycles cleared.
  - While rst is high, stall=0, issue_fire=0 and forward_sel=0, regardless of inputs.
- Forwarding (combinational, per lane i):
  - 01 if ex_mem_reg_write, ex_mem_rd_addr!=0 and ex_mem_rd_addr==ex_rs[i].
  - Otherwise 10 if the same conditions hold for MEM/WB.
  - Otherwise 00.
  - EX/MEM has priority when both match. x0 is never forwarded.
- Scoreboard state: per register a pending bit plus a LAT_W counter.
  - Every cycle, each nonzero counter decrements by 1.
  - Pending clears in the cycle the counter transitions 1->0.
- Scoreboard allocation: on issue_fire with issue_reg_write, issue_rd_addr!=0 and issue_latency>0, set pending[rd]=1 and counter=issue_latency at the next edge.
  - Allocation overrides a same-cycle expiry on that register.
  - A latency-0 issue does not touch the scoreboard.
- Stall (combinational) = ~rst & issue_valid & ~flush & (A | B | C):
  - A, load-use: some lane i has id_rs_used[i], id_rs[i]!=0, id_ex_mem_read and id_ex_rd_addr==id_rs[i].
  - B, RAW: some lane i has id_rs_used[i] and pending[id_rs[i]].
  - C, WAW: issue_reg_write and pending[issue_rd_addr].
- x0 is never pending and never causes a stall.
- flush: stall=0 and no allocation that cycle; in-flight scoreboard entries continue counting (long ops are non-cancellable).
- Load-use stalls last exactly 1 cycle. Scoreboard stalls last until the counter expires.
- No state other than the scoreboard and the counter; forward_sel has zero latency.

Optional Feature:
- Macro FWD_STALL_COUNTER_EN.
- Defined: stall_cycles increments by 1 on each clk edge where stall=1; it saturates at 0xFFFFFFFF and clears on rst.
- Undefined: no counter register; stall_cycles is tied to 0. The port remains so the integration is identical either way.

Decomposition:
- Shared constants include: FWD_NONE=2'b00, FWD_EX_MEM=2'b01, FWD_MEM_WB=2'b10, and default REG_AW.
- One sub-module, forward_select_lane: combinational single-lane priority select, instantiated NUM_SRC times via generate.
- Scoreboard and stall logic stay in the top module.

Test Plan:
- Forward priority: ex_mem_rd=5 (wr=1), mem_wb_rd=5 (wr=1), ex_rs0=5 -> lane0=01. Then ex_mem_reg_write=0 -> lane0=10. Then ex_rs0=0 with both rd=0 -> 00.
- Load-use: id_ex_mem_read=1, id_ex_rd=7, id_rs1=7, used=1, issue_valid=1 -> stall=1 for exactly that cycle, issue_fire=0. Next cycle with id_ex_mem_read=0 -> stall=0.
- Scoreboard RAW: issue rd=9, latency=3 at cycle t. A dependent instruction reading x9 at t+1 -> stall=1 at t+1, t+2; stall=0 and issue_fire=1 at t+3.
- WAW plus re-allocation:
  - Issue rd=4, latency=2; next cycle issue rd=4 -> stall=1.
  - Issue rd=4 in the expiry cycle -> new latency loaded and pending stays 1.
- Flush and reset:
  - flush=1 while RAW-stalled -> stall=0, no allocation; the pending entry still expires on schedule.
  - rst pulse mid-countdown -> all pending cleared next cycle; a reader of that register is not stalled.
- With FWD_STALL_COUNTER_EN: 5 stall cycles -> stall_cycles=5. Without it: stall_cycles=0 throughout.
